// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the data-cache responder.
// Helpers return 32-bit fields; callers size-cast to their own widths.
package cache_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE
    } dc_state_t;

    function automatic logic [31:0] off_of(
        input logic [31:0] addr,
        input int          off_w
    );
        return (addr >> 2) & ((32'd1 << off_w) - 32'd1);
    endfunction

    function automatic logic [31:0] idx_of(
        input logic [31:0] addr,
        input int          off_w,
        input int          idx_w
    );
        return (addr >> (2 + off_w)) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] tag_of(
        input logic [31:0] addr,
        input int          off_w,
        input int          idx_w
    );
        return addr >> (2 + off_w + idx_w);
    endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Valid + tag storage for the direct-mapped data cache.
// Valid bits clear on reset; tags are left as-is.
module dcache_tag_array #(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] lk_idx,
    input  logic [TAG_W-1:0] lk_tag,
    output logic             hit,
    input  logic             we,
    input  logic             wr_valid,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [0:LINES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_idx] <= wr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && we) begin
            tags[wr_idx] <= wr_tag;
        end
    end

    assign hit = valid[lk_idx] && (tags[lk_idx] == lk_tag);

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache
// between the core's dCache port and a req/ack word memory.
module dcache_responder
    import cache_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dCacheAddr,
    input  logic              dCacheReadEn,
    input  logic              dCacheWriteEn,
    input  logic [31:0]       dCacheWriteData,
    output logic [31:0]       dCacheReadData,
    output logic              dCacheStall,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWriteData,
    input  logic              memAck,
    input  logic [31:0]       memReadData
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS_PER_LINE - 1);

    dc_state_t         state;
    logic [OFF_W-1:0]  beat;
    logic [OFF_W-1:0]  beat_nxt;
    logic [31:0]       rdata_q;
    logic [31:0]       data_arr [0:LINES-1][0:WORDS_PER_LINE-1];

    logic [ADDR_W-1:0] lk_addr;
    logic [OFF_W-1:0]  lk_off;
    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              hit;
    logic              rd_req;
    logic              rd_hit;
    logic              rd_miss;
    logic              tag_we;
    logic [31:0]       hit_data;

    // Outside IDLE the lookup follows the in-flight memory address.
    assign lk_addr  = (state == IDLE) ? dCacheAddr : memAddr;
    assign lk_off   = OFF_W'(off_of(lk_addr, OFF_W));
    assign lk_idx   = IDX_W'(idx_of(lk_addr, OFF_W, IDX_W));
    assign lk_tag   = TAG_W'(tag_of(lk_addr, OFF_W, IDX_W));
    assign beat_nxt = beat + 1'b1;

    assign rd_req   = (state == IDLE) && dCacheReadEn && !dCacheWriteEn;
    assign rd_hit   = rd_req && hit;
    assign rd_miss  = rd_req && !hit;
    assign hit_data = data_arr[lk_idx][lk_off];

    assign tag_we = rd_miss ||
                    ((state == REFILL) && memAck && (beat == LAST));

    dcache_tag_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tags (
        .clk      (clk),
        .rst      (rst),
        .lk_idx   (lk_idx),
        .lk_tag   (lk_tag),
        .hit      (hit),
        .we       (tag_we),
        .wr_valid (state == REFILL),
        .wr_idx   (lk_idx),
        .wr_tag   (lk_tag)
    );

    assign dCacheReadData = rd_hit ? hit_data : rdata_q;

    always_comb begin
        dCacheStall = 1'b1;
        unique case (1'b1)
            (state == IDLE):   dCacheStall = dCacheWriteEn || rd_miss;
            (state == REFILL): dCacheStall = 1'b1;
            (state == WRITE):  dCacheStall = !memAck;
            default:           dCacheStall = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beat         <= '0;
            memReq       <= 1'b0;
            memWe        <= 1'b0;
            memAddr      <= '0;
            memWriteData <= '0;
            rdata_q      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dCacheWriteEn) begin
                        state        <= WRITE;
                        memReq       <= 1'b1;
                        memWe        <= 1'b1;
                        memAddr      <= {dCacheAddr[ADDR_W-1:2], 2'b00};
                        memWriteData <= dCacheWriteData;
                    end else if (rd_hit) begin
                        rdata_q <= hit_data;
                    end else if (rd_miss) begin
                        state   <= REFILL;
                        beat    <= '0;
                        memReq  <= 1'b1;
                        memWe   <= 1'b0;
                        memAddr <= {dCacheAddr[ADDR_W-1:2+OFF_W],
                                    {(OFF_W+2){1'b0}}};
                    end
                end
                REFILL: begin
                    if (memAck) begin
                        if (beat == LAST) begin
                            state  <= IDLE;
                            memReq <= 1'b0;
                        end else begin
                            beat    <= beat_nxt;
                            memAddr <= {memAddr[ADDR_W-1:2+OFF_W],
                                        beat_nxt, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    if (memAck) begin
                        state  <= IDLE;
                        memReq <= 1'b0;
                        memWe  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Refill beats fill the line; write-through only touches resident lines.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if ((state == REFILL) && memAck) begin
                data_arr[lk_idx][beat] <= memReadData;
            end
            if ((state == WRITE) && memAck && hit) begin
                data_arr[lk_idx][lk_off] <= memWriteData;
            end
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: a delayed-ack memory model
// checks every beat; core-side tasks check stall, hit and load data.
module tb_dcache_responder;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dCacheAddr = '0;
    logic        dCacheReadEn = 1'b0;
    logic        dCacheWriteEn = 1'b0;
    logic [31:0] dCacheWriteData = '0;
    logic [31:0] dCacheReadData;
    logic        dCacheStall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic        memAck = 1'b0;
    logic [31:0] memReadData = '0;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;

    beat_t       sb [$];
    logic [31:0] memw [logic [31:0]];
    bit          vm [16];
    logic [23:0] tm [16];

    always #5 clk = ~clk;

    dcache_responder dut (
        .clk             (clk),
        .rst             (rst),
        .dCacheAddr      (dCacheAddr),
        .dCacheReadEn    (dCacheReadEn),
        .dCacheWriteEn   (dCacheWriteEn),
        .dCacheWriteData (dCacheWriteData),
        .dCacheReadData  (dCacheReadData),
        .dCacheStall     (dCacheStall),
        .memReq          (memReq),
        .memWe           (memWe),
        .memAddr         (memAddr),
        .memWriteData    (memWriteData),
        .memAck          (memAck),
        .memReadData     (memReadData)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (memw.exists(a)) return memw[a];
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Memory: acks each beat two cycles after it is seen.
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            memAck = 1'b0;
            ack_cnt = 0;
        end else if (memAck) begin
            memAck = 1'b0;
            ack_cnt = 0;
        end else if (memReq) begin
            if (ack_cnt == 2) begin
                memAck = 1'b1;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL mem_beat: unexpected addr=%h we=%b",
                             memAddr, memWe);
                end else begin
                    b = sb.pop_front();
                    if (memAddr !== b.addr || memWe !== b.we ||
                        (b.we && memWriteData !== b.data)) begin
                        errors++;
                        $display("FAIL mem_beat: got a=%h we=%b d=%h exp a=%h we=%b d=%h",
                                 memAddr, memWe, memWriteData,
                                 b.addr, b.we, b.data);
                    end
                end
                if (memWe) memw[memAddr] = memWriteData;
                else memReadData = mem_val(memAddr);
            end else begin
                ack_cnt++;
            end
        end else begin
            ack_cnt = 0;
        end
    end

    function automatic bit model_hit(input logic [31:0] a);
        return vm[a[7:4]] && (tm[a[7:4]] == a[31:8]);
    endfunction

    task automatic do_read(input logic [31:0] a, input bit exp_hit,
                           input string nm);
        logic [31:0] exp;
        logic [31:0] base;
        int n;
        exp  = mem_val({a[31:2], 2'b00});
        base = {a[31:4], 4'h0};
        if (!exp_hit)
            for (int i = 0; i < 4; i++)
                sb.push_back('{1'b0, base + 32'(4 * i), 32'h0});
        @(posedge clk); #1;
        dCacheAddr   = a;
        dCacheReadEn = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (dCacheStall !== logic'(!exp_hit)) begin
            errors++;
            $display("FAIL %s_stall0: got %b exp %b", nm, dCacheStall, !exp_hit);
        end
        n = 0;
        while (dCacheStall && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (dCacheStall !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: stall stuck %b", nm, dCacheStall);
        end
        checks++;
        if (dCacheReadData !== exp) begin
            errors++;
            $display("FAIL %s_data: got %h exp %h", nm, dCacheReadData, exp);
        end
        checks++;
        if (memReq !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_beats: memReq %b left %0d exp 0 0",
                     nm, memReq, sb.size());
        end
        @(posedge clk); #1;
        dCacheReadEn = 1'b0;
        vm[a[7:4]] = 1'b1;
        tm[a[7:4]] = a[31:8];
        sb.delete();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input string nm);
        int n;
        sb.push_back('{1'b1, {a[31:2], 2'b00}, d});
        @(posedge clk); #1;
        dCacheAddr      = a;
        dCacheWriteData = d;
        dCacheWriteEn   = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (dCacheStall !== 1'b1) begin
            errors++;
            $display("FAIL %s_stall0: got %b exp 1", nm, dCacheStall);
        end
        n = 0;
        while (dCacheStall && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (dCacheStall !== 1'b0 || memAck !== 1'b1 ||
            memReq !== 1'b1 || memWe !== 1'b1) begin
            errors++;
            $display("FAIL %s_ackcycle: stall %b ack %b req %b we %b exp 0 1 1 1",
                     nm, dCacheStall, memAck, memReq, memWe);
        end
        @(posedge clk); #1;
        dCacheWriteEn = 1'b0;
        checks++;
        if (sb.size() != 0 || memReq !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: left %0d req %b exp 0 0",
                     nm, sb.size(), memReq);
        end
        sb.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (memReq !== 1'b0 || memWe !== 1'b0 || memAddr !== 32'h0 ||
            memWriteData !== 32'h0 || dCacheReadData !== 32'h0 ||
            dCacheStall !== 1'b0) begin
            errors++;
            $display("FAIL reset: req %b we %b a %h d %h rd %h st %b exp all 0",
                     memReq, memWe, memAddr, memWriteData,
                     dCacheReadData, dCacheStall);
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) vm[i] = 1'b0;
    endtask

    task automatic test_cold_read();
        do_read(32'h100, 1'b0, "cold_read");
    endtask

    task automatic test_hit_and_hold();
        do_read(32'h108, 1'b1, "hit_108");
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (dCacheReadData !== mem_val(32'h108) || dCacheStall !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: rd %h st %b exp %h 0",
                     dCacheReadData, dCacheStall, mem_val(32'h108));
        end
    endtask

    task automatic test_write_hit();
        do_write(32'h104, 32'hDEADBEEF, "wr_hit");
        do_read(32'h104, 1'b1, "rd_after_wr");
    endtask

    task automatic test_write_miss();
        do_write(32'h2000, 32'h12345678, "wr_miss");
        do_read(32'h2000, 1'b0, "rd_no_alloc");
    endtask

    task automatic test_conflict();
        do_read(32'h100, 1'b0, "conf_a");
        do_read(32'h200, 1'b0, "conf_b");
        do_read(32'h100, 1'b0, "conf_a_again");
    endtask

    task automatic test_reset_refill();
        int n;
        for (int i = 0; i < 4; i++)
            sb.push_back('{1'b0, 32'h300 + 32'(4 * i), 32'h0});
        @(posedge clk); #1;
        dCacheAddr   = 32'h300;
        dCacheReadEn = 1'b1;
        n = 0;
        while (sb.size() > 2 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (sb.size() != 2) begin
            errors++;
            $display("FAIL rst_refill_wait: left %0d exp 2", sb.size());
        end
        @(posedge clk); #1;
        rst = 1'b1;
        dCacheReadEn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (memReq !== 1'b0 || dCacheReadData !== 32'h0) begin
            errors++;
            $display("FAIL rst_refill_drop: req %b rd %h exp 0 0",
                     memReq, dCacheReadData);
        end
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 16; i++) vm[i] = 1'b0;
        do_read(32'h300, 1'b0, "rst_reread");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 12; i++) begin
            a = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 3) == 0)
                do_write(a, $urandom, "rnd_wr");
            else
                do_read(a, model_hit(a), "rnd_rd");
        end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_hit_and_hold();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_reset_refill();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
